// File: rtl/trivium_comp.sv
// rtl/trivium_comp.sv - Trivium keystream generator, W rounds per clock; TRIVIUM_KEY_CLEAR_EN wipes the key after each run
module trivium_comp #(
    parameter int OUT_BITS = 4096,
    parameter int W        = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [79:0]         Kin,
    input  logic [79:0]         Din,
    output logic [OUT_BITS-1:0] Dout,
    input  logic                Krdy,
    input  logic                Drdy,
    input  logic                EncDec,
    input  logic                EN,
    output logic                BSY,
    output logic                Kvld,
    output logic                Dvld
);

    localparam int INIT_CYC = 1152 / W;
    localparam int GEN_CYC  = OUT_BITS / W;
    localparam int CW       = $clog2((1152 + OUT_BITS) / W + 1);

    typedef enum logic [1:0] {IDLE, INIT, GEN, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          cnt_last;
    logic [79:0]   key;
    logic          key_vld;
    logic          kvld_r;
    logic          enc_dec;
    logic [287:0]  st;        // st[i-1] holds s_i
    logic [287:0]  st_load;
    logic [287:0]  st_rnd;
    logic [287:0]  rs;
    logic [W-1:0]  zw;
    logic          t1, t2, t3;

    assign cnt_last = (state == INIT) ? (cnt == CW'(INIT_CYC - 1))
                                      : (cnt == CW'(GEN_CYC - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (!Krdy && Drdy && key_vld) state_nx = INIT;
            INIT: if (cnt_last) state_nx = GEN;
            GEN:  if (cnt_last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Byte-reversed, bit-ascending load order of key and IV
    always_comb begin
        st_load = '0;
        for (int i = 0; i < 80; i++) begin
            st_load[i]      = key[72 - 8 * (i >> 3) + (i & 7)];
            st_load[93 + i] = Din[72 - 8 * (i >> 3) + (i & 7)];
        end
        st_load[287:285] = 3'b111;
    end

    always_comb begin
        rs = st;
        zw = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        for (int r = 0; r < W; r++) begin
            t1 = rs[65] ^ rs[92];
            t2 = rs[161] ^ rs[176];
            t3 = rs[242] ^ rs[287];
            zw[W-1-r] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (rs[90] & rs[91]) ^ rs[170];
            t2 = t2 ^ (rs[174] & rs[175]) ^ rs[263];
            t3 = t3 ^ (rs[285] & rs[286]) ^ rs[68];
            rs = {rs[286:177], t2, rs[175:93], t1, rs[91:0], t3};
        end
        st_rnd = rs;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            st      <= '0;
            Dout    <= '0;
            key     <= '0;
            key_vld <= 1'b0;
            kvld_r  <= 1'b0;
            enc_dec <= 1'b0;
        end else if (EN) begin
            state  <= state_nx;
            kvld_r <= (state == IDLE) && Krdy;
            case (state)
                IDLE: begin
                    if (Krdy) begin
                        key     <= Kin;
                        key_vld <= 1'b1;
                    end else if (Drdy && key_vld) begin
                        st      <= st_load;
                        Dout    <= '0;
                        cnt     <= '0;
                        enc_dec <= EncDec;
                    end
                end
                INIT: begin
                    st  <= st_rnd;
                    cnt <= cnt_last ? '0 : cnt + CW'(1);
                end
                GEN: begin
                    st   <= st_rnd;
                    Dout <= (Dout << W) | OUT_BITS'(zw);
                    cnt  <= cnt + CW'(1);
                end
                DONE: begin
`ifdef TRIVIUM_KEY_CLEAR_EN
                    key     <= '0;
                    key_vld <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign BSY  = (state != IDLE);
    assign Dvld = (state == DONE);
    assign Kvld = kvld_r;

endmodule

// File: tb/tb_trivium_comp.sv
// tb/tb_trivium_comp.sv - directed bench for trivium_comp against a bit-serial reference model
module tb_trivium_comp;

    localparam int OB = 4096;

    logic          CLK = 1'b0;
    logic          RST, Krdy, Drdy, EncDec, EN;
    logic [79:0]   Kin, Din;
    logic [OB-1:0] Dout;
    logic          BSY, Kvld, Dvld;

    int checks = 0;
    int errors = 0;

    trivium_comp #(.OUT_BITS(OB), .W(1)) dut (
        .CLK(CLK), .RST(RST), .Kin(Kin), .Din(Din), .Dout(Dout),
        .Krdy(Krdy), .Drdy(Drdy), .EncDec(EncDec), .EN(EN),
        .BSY(BSY), .Kvld(Kvld), .Dvld(Dvld)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic  krdy, drdy, en;
        logic  bsy, kvld;
        string name;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_dout(input string name, input logic [OB-1:0] exp);
        checks++;
        if (Dout !== exp) begin
            errors++;
            $display("FAIL %s got_top=%h exp_top=%h got_low=%h exp_low=%h",
                     name, Dout[OB-1 -: 64], exp[OB-1 -: 64], Dout[63:0], exp[63:0]);
        end
    endtask

    // Straight textbook Trivium over a 1-based bit array
    function automatic logic [OB-1:0] model(input logic [79:0] k, input logic [79:0] iv);
        logic          s [1:288];
        logic          a, b, c, z;
        logic [OB-1:0] ks;
        int            bb, jj;
        ks = '0;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            bb = (i - 1) >> 3;
            jj = (i - 1) & 7;
            s[i]      = k[72 - 8 * bb + jj];
            s[93 + i] = iv[72 - 8 * bb + jj];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int r = 0; r < 1152 + OB; r++) begin
            a = s[66] ^ s[93];
            b = s[162] ^ s[177];
            c = s[243] ^ s[288];
            z = a ^ b ^ c;
            a = a ^ (s[91] & s[92]) ^ s[171];
            b = b ^ (s[175] & s[176]) ^ s[264];
            c = c ^ (s[286] & s[287]) ^ s[69];
            for (int i = 93; i >= 2; i--) s[i] = s[i-1];
            s[1] = c;
            for (int i = 177; i >= 95; i--) s[i] = s[i-1];
            s[94] = a;
            for (int i = 288; i >= 179; i--) s[i] = s[i-1];
            s[178] = b;
            if (r >= 1152) ks[OB - 1 - (r - 1152)] = z;
        end
        return ks;
    endfunction

    task automatic load_key(input logic [79:0] k);
        Kin  = k;
        Krdy = 1'b1;
        @(negedge CLK);
        Krdy = 1'b0;
        @(negedge CLK);
    endtask

    // m counts negedges seen with BSY high; Dout at negedge m holds m-1153 GEN bits
    task automatic run(input string tag, input logic [79:0] iv, input int stall_at,
                       input int abort_at, input int exp_bsy, input logic [OB-1:0] ks);
        int            m;
        int            dv;
        logic [OB-1:0] part;
        m  = 0;
        dv = 0;
        Din    = iv;
        EncDec = ~EncDec;
        Drdy   = 1'b1;
        @(negedge CLK);
        Drdy = 1'b0;
        chk({tag, " bsy_rise"}, 64'(BSY), 64'd1);
        while (BSY && m < 7000) begin
            m++;
            if (Dvld) begin
                dv++;
                chk_dout({tag, " dout_at_dvld"}, ks);
            end
            if (m == stall_at) begin
                part = ks >> (OB - (m - 1153));
                EN = 1'b0;
                repeat (10) begin
                    @(negedge CLK);
                    m++;
                    chk({tag, " stall_bsy"}, 64'(BSY), 64'd1);
                    chk_dout({tag, " stall_dout"}, part);
                end
                EN = 1'b1;
            end
            if (m == abort_at) begin
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
                chk({tag, " abort_bsy"}, 64'(BSY), 64'd0);
                chk({tag, " abort_dvld"}, 64'(Dvld), 64'd0);
                chk({tag, " abort_kvld"}, 64'(Kvld), 64'd0);
                chk_dout({tag, " abort_dout"}, '0);
                chk({tag, " abort_no_dvld_seen"}, 64'(dv), 64'd0);
                return;
            end
            @(negedge CLK);
        end
        chk({tag, " bsy_cycles"}, 64'(m), 64'(exp_bsy));
        chk({tag, " dvld_pulses"}, 64'(dv), 64'd1);
        chk({tag, " dvld_low_after"}, 64'(Dvld), 64'd0);
    endtask

    initial begin
        vec_t          tbl [7];
        logic [79:0]   key1, iv2;
        logic [OB-1:0] ks1, ks2;

        key1 = 80'hFF000102030405060708;
        iv2  = 80'h0123456789ABCDEF0011;
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "drdy_without_key"};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "key_load"};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "kvld_hold_en0_a"};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "kvld_hold_en0_b"};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "kvld_resume_clear"};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "krdy_priority"};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "idle_quiet"};

        ks1 = model(key1, 80'h0);
        ks2 = model(key1, iv2);

        RST = 1'b1; Krdy = 1'b0; Drdy = 1'b0; EncDec = 1'b0; EN = 1'b1;
        Kin = key1; Din = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_bsy", 64'(BSY), 64'd0);
        chk("rst_kvld", 64'(Kvld), 64'd0);
        chk("rst_dvld", 64'(Dvld), 64'd0);
        chk_dout("rst_dout", '0);
        RST = 1'b0;

        for (int i = 0; i < 7; i++) begin
            Krdy = tbl[i].krdy;
            Drdy = tbl[i].drdy;
            EN   = tbl[i].en;
            @(negedge CLK);
            chk({tbl[i].name, " bsy"}, 64'(BSY), 64'(tbl[i].bsy));
            chk({tbl[i].name, " kvld"}, 64'(Kvld), 64'(tbl[i].kvld));
        end
        Krdy = 1'b0; Drdy = 1'b0; EN = 1'b1;

        run("run1", 80'h0, 0, 0, 5249, ks1);
        repeat (5) @(negedge CLK);
        chk_dout("run1 dout_hold", ks1);
        chk("run1 idle_bsy", 64'(BSY), 64'd0);

        load_key(key1);
        run("stall", iv2, 3000, 0, 5259, ks2);
        chk_dout("stall dout_final", ks2);

`ifdef TRIVIUM_KEY_CLEAR_EN
        Drdy = 1'b1;
        @(negedge CLK);
        Drdy = 1'b0;
        chk("cleared_key_drdy_ignored", 64'(BSY), 64'd0);
        @(negedge CLK);
        load_key(key1);
`endif
        run("abort", 80'h0, 0, 2000, 0, ks1);

        Drdy = 1'b1;
        @(negedge CLK);
        Drdy = 1'b0;
        chk("key_lost_after_rst", 64'(BSY), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
